// File: rtl/count_pwm_gen_if.sv
// Signal bundle between the COUNTER consumer and its surrounding logic.
// The master side drives counter phase and duty writes; the slave side is the PWM generator.
interface count_pwm_gen_if #(
    parameter int CNT_W = 4,
    parameter int PCW   = 8
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W:0]   duty_in;
    logic             duty_we;
    logic             err_clr;
    logic             duty_pend;
    logic [CNT_W:0]   duty_act;
    logic             pwm_out;
    logic             wrap;
    logic             resync;
    logic [PCW-1:0]   period_cnt;
    logic             seq_err;

    modport master (
        output cnt_q, duty_in, duty_we, err_clr,
        input  duty_pend, duty_act, pwm_out, wrap, resync, period_cnt, seq_err
    );

    modport slave (
        input  cnt_q, duty_in, duty_we, err_clr,
        output duty_pend, duty_act, pwm_out, wrap, resync, period_cnt, seq_err
    );
endinterface

// File: rtl/count_pwm_gen.sv
// PWM generator driven by a free-running counter phase, with double-buffered duty,
// wrap/resync detection, completed-period counting and sticky sequence-error flag.
module count_pwm_gen #(
    parameter int CNT_W    = 4,
    parameter int PCW      = 8,
    parameter int DUTY_RST = 8,
    parameter int PWM_POL  = 1
) (
    input logic             clk_i,
    input logic             rst_i,
    count_pwm_gen_if.slave  bus
);
    localparam int             DW       = CNT_W + 1;
    localparam logic [DW-1:0]  DUTY_MAX = DW'(1 << CNT_W);
    localparam logic [DW-1:0]  DUTY_INI = DW'(DUTY_RST);
    localparam logic           POL      = (PWM_POL != 0);

    function automatic logic [DW-1:0] clamp_duty(input logic [DW-1:0] d);
        return (d > DUTY_MAX) ? DUTY_MAX : d;
    endfunction

    logic [CNT_W-1:0] prev_q_q;
    logic             prev_vld_q;
    logic [DW-1:0]    shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic [DW-1:0]    act_q, duty_eff;
    logic             pwm_q, pwm_d;
    logic             wrap_q, resync_q, err_q;
    logic [PCW-1:0]   per_q;

    logic [CNT_W-1:0] exp_cnt;
    logic             wrap_ev, resync_ev, err_ev, load_ev, active;
    logic [DW-1:0]    duty_wr;

    always_comb begin
        exp_cnt   = prev_q_q + 1'b1;
        wrap_ev   = prev_vld_q && (bus.cnt_q == exp_cnt) && (prev_q_q == '1);
        resync_ev = prev_vld_q && (bus.cnt_q == '0) && (prev_q_q != '1);
        err_ev    = prev_vld_q && (bus.cnt_q != exp_cnt) && !resync_ev;
        load_ev   = wrap_ev || resync_ev;
        duty_wr   = clamp_duty(bus.duty_in);

        duty_eff = act_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        if (load_ev) begin
            // A write landing on the load cycle goes straight to the active duty.
            pend_d   = 1'b0;
            if (bus.duty_we)
                duty_eff = duty_wr;
            else if (pend_q)
                duty_eff = shadow_q;
        end else if (bus.duty_we) begin
            shadow_d = duty_wr;
            pend_d   = 1'b1;
        end

        active = ({1'b0, bus.cnt_q} < duty_eff);
        pwm_d  = POL ? active : !active;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q_q   <= '0;
            prev_vld_q <= 1'b0;
            shadow_q   <= DUTY_INI;
            pend_q     <= 1'b0;
            act_q      <= DUTY_INI;
            pwm_q      <= !POL;
            wrap_q     <= 1'b0;
            resync_q   <= 1'b0;
            err_q      <= 1'b0;
            per_q      <= '0;
        end else begin
            prev_q_q   <= bus.cnt_q;
            prev_vld_q <= 1'b1;
            shadow_q   <= shadow_d;
            pend_q     <= pend_d;
            act_q      <= duty_eff;
            pwm_q      <= pwm_d;
            wrap_q     <= wrap_ev;
            resync_q   <= resync_ev;
            if (wrap_ev)
                per_q <= per_q + 1'b1;
            // A new error outranks a simultaneous clear.
            if (err_ev)
                err_q <= 1'b1;
            else if (bus.err_clr)
                err_q <= 1'b0;
        end
    end

    assign bus.duty_pend  = pend_q;
    assign bus.duty_act   = act_q;
    assign bus.pwm_out    = pwm_q;
    assign bus.wrap       = wrap_q;
    assign bus.resync     = resync_q;
    assign bus.period_cnt = per_q;
    assign bus.seq_err    = err_q;
endmodule

// File: tb/tb_count_pwm_gen.sv
// Directed bench for count_pwm_gen: PWM shape, duty buffering, wrap/resync, errors, rollover, reset.
module tb_count_pwm_gen;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    count_pwm_gen_if #(.CNT_W(4), .PCW(8)) bus ();

    count_pwm_gen #(.CNT_W(4), .PCW(8), .DUTY_RST(8), .PWM_POL(1)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] c);
        bus.cnt_q = c;
        tick();
    endtask

    initial begin
        rst         = 1'b1;
        bus.cnt_q   = 4'd0;
        bus.duty_in = 5'd0;
        bus.duty_we = 1'b0;
        bus.err_clr = 1'b0;
        tick();
        check("rst_pwm", bus.pwm_out, 0);
        check("rst_wrap", bus.wrap, 0);
        check("rst_resync", bus.resync, 0);
        check("rst_err", bus.seq_err, 0);
        check("rst_pend", bus.duty_pend, 0);
        check("rst_per", bus.period_cnt, 0);
        check("rst_act", bus.duty_act, 8);
        rst = 1'b0;

        // Reset duty 8: first period (no wrap seen yet), then a wrapping period.
        for (int p = 0; p < 16; p++) begin
            step(4'(p));
            check($sformatf("t1a_pwm_p%0d", p), bus.pwm_out, (p < 8));
            check($sformatf("t1a_wrap_p%0d", p), bus.wrap, 0);
        end
        for (int p = 0; p < 16; p++) begin
            step(4'(p));
            check($sformatf("t1b_pwm_p%0d", p), bus.pwm_out, (p < 8));
            check($sformatf("t1b_wrap_p%0d", p), bus.wrap, (p == 0));
        end
        check("t1_per", bus.period_cnt, 1);

        // Buffered write of 4 at phase 6.
        for (int p = 0; p < 16; p++) begin
            bus.duty_we = (p == 6);
            bus.duty_in = 5'd4;
            step(4'(p));
            check($sformatf("t2a_pwm_p%0d", p), bus.pwm_out, (p < 8));
            check($sformatf("t2a_pend_p%0d", p), bus.duty_pend, (p >= 6));
            check($sformatf("t2a_act_p%0d", p), bus.duty_act, 8);
        end
        bus.duty_we = 1'b0;
        for (int p = 0; p < 16; p++) begin
            bus.duty_we = (p == 10);
            bus.duty_in = 5'd2;
            step(4'(p));
            check($sformatf("t2b_pwm_p%0d", p), bus.pwm_out, (p < 4));
            check($sformatf("t2b_pend_p%0d", p), bus.duty_pend, (p >= 10));
            if (p == 0) begin
                check("t2b_act", bus.duty_act, 4);
                check("t2b_wrap", bus.wrap, 1);
            end
        end
        bus.duty_we = 1'b0;
        check("t2_per", bus.period_cnt, 3);

        // Write of 20 on the wrap cycle: clamped, bypasses the pending 2.
        for (int p = 0; p < 16; p++) begin
            bus.duty_we = (p == 0);
            bus.duty_in = 5'd20;
            step(4'(p));
            check($sformatf("t3_pwm_p%0d", p), bus.pwm_out, 1);
            if (p == 0) begin
                check("t3_act", bus.duty_act, 16);
                check("t3_pend", bus.duty_pend, 0);
            end
        end
        bus.duty_we = 1'b0;

        // Sequence error 6->9, sticky, cleared; error beats clear.
        step(4'd0);
        check("t4_wrap", bus.wrap, 1);
        check("t4_act_kept", bus.duty_act, 16);
        check("t4_per", bus.period_cnt, 5);
        for (int p = 1; p <= 6; p++) step(4'(p));
        check("t4_err_before", bus.seq_err, 0);
        step(4'd9);
        check("t4_err_set", bus.seq_err, 1);
        step(4'd10);
        check("t4_err_sticky", bus.seq_err, 1);
        bus.err_clr = 1'b1;
        step(4'd11);
        check("t4_err_clr", bus.seq_err, 0);
        step(4'd13);
        check("t4_err_wins", bus.seq_err, 1);
        step(4'd14);
        check("t4_err_clr2", bus.seq_err, 0);
        bus.err_clr = 1'b0;

        // Resync 7->0 loads the pending duty without counting a period.
        step(4'd15);
        step(4'd0);
        check("t5_per_pre", bus.period_cnt, 6);
        for (int p = 1; p <= 7; p++) begin
            bus.duty_we = (p == 5);
            bus.duty_in = 5'd3;
            step(4'(p));
        end
        bus.duty_we = 1'b0;
        check("t5_pend", bus.duty_pend, 1);
        check("t5_pwm7", bus.pwm_out, 1);
        step(4'd0);
        check("t5_resync", bus.resync, 1);
        check("t5_wrap", bus.wrap, 0);
        check("t5_per", bus.period_cnt, 6);
        check("t5_act", bus.duty_act, 3);
        check("t5_pend_clr", bus.duty_pend, 0);
        check("t5_err", bus.seq_err, 0);
        check("t5_pwm0", bus.pwm_out, 1);
        step(4'd1);
        check("t5_resync_off", bus.resync, 0);
        step(4'd2);
        check("t5_pwm2", bus.pwm_out, 1);
        step(4'd3);
        check("t5_pwm3", bus.pwm_out, 0);

        // Period counter rollover.
        for (int p = 4; p < 16; p++) step(4'(p));
        step(4'd0);
        check("t6_per7", bus.period_cnt, 7);
        for (int n = 0; n < 248; n++) begin
            for (int p = 1; p < 16; p++) step(4'(p));
            step(4'd0);
        end
        check("t6_per255", bus.period_cnt, 255);
        for (int p = 1; p < 16; p++) begin
            bus.duty_we = (p == 1);
            bus.duty_in = 5'd0;
            step(4'(p));
        end
        bus.duty_we = 1'b0;
        step(4'd0);
        check("t6_roll", bus.period_cnt, 0);
        check("t6_roll_wrap", bus.wrap, 1);
        check("t6_act0", bus.duty_act, 0);
        for (int p = 0; p < 16; p++) begin
            if (p != 0) step(4'(p));
            check($sformatf("t6_duty0_p%0d", p), bus.pwm_out, 0);
        end

        // Mid-period reset drops pending duty and error.
        step(4'd0);
        for (int p = 1; p <= 5; p++) begin
            bus.duty_we = (p == 3);
            bus.duty_in = 5'd9;
            step(4'(p));
        end
        bus.duty_we = 1'b0;
        step(4'd8);
        check("t6_pre_err", bus.seq_err, 1);
        check("t6_pre_pend", bus.duty_pend, 1);
        rst = 1'b1;
        step(4'd7);
        check("t6_rst_pwm", bus.pwm_out, 0);
        check("t6_rst_pend", bus.duty_pend, 0);
        check("t6_rst_act", bus.duty_act, 8);
        check("t6_rst_per", bus.period_cnt, 0);
        check("t6_rst_err", bus.seq_err, 0);
        check("t6_rst_wrap", bus.wrap, 0);
        rst = 1'b0;
        step(4'd0);
        check("t6_novld_err", bus.seq_err, 0);
        check("t6_novld_resync", bus.resync, 0);
        check("t6_novld_pwm", bus.pwm_out, 1);
        for (int p = 1; p < 16; p++) step(4'(p));
        step(4'd0);
        check("t6_post_wrap", bus.wrap, 1);
        check("t6_post_act", bus.duty_act, 8);
        check("t6_post_per", bus.period_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
